// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment driver for the countdown timer: BCD decode,
// tens-of-minutes zero blanking, colon on the minutes digit and blinking when done.
module display_scan #(
  parameter int SCAN_COUNT  = 50000,
  parameter int SCAN_WIDTH  = 16,
  parameter int BLINK_TICKS = 64,
  parameter int BLINK_WIDTH = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] seconds,
  input  logic [3:0] tens_seconds,
  input  logic [3:0] minutes,
  input  logic [3:0] tens_minutes,
  input  logic       done,
  input  logic       blank_lead,
  output logic [3:0] anode,
  output logic [6:0] segments,
  output logic       dp
);

  localparam logic [SCAN_WIDTH-1:0]  SCAN_LAST  = SCAN_WIDTH'(SCAN_COUNT - 1);
  localparam logic [BLINK_WIDTH-1:0] BLINK_LAST = BLINK_WIDTH'(BLINK_TICKS - 1);

  logic [SCAN_WIDTH-1:0]  prescale_q, prescale_d;
  logic [1:0]             idx_q, idx_d;
  logic [BLINK_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
  logic                   blink_on_q, blink_on_d;
  logic [3:0]             anode_q, anode_d;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d;

  logic       tick;
  logic [3:0] digit;
  logic       lead_blank;
  logic       dark;

  assign tick = (prescale_q == SCAN_LAST);

  always_comb begin
    prescale_d  = tick ? '0 : prescale_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!done) begin
      // Leaving the done state makes the display visible straight away.
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    digit = seconds;
    case (idx_q)
      2'd0:    digit = seconds;
      2'd1:    digit = tens_seconds;
      2'd2:    digit = minutes;
      default: digit = tens_minutes;
    endcase
  end

  assign lead_blank = (idx_q == 2'd3) && blank_lead && (tens_minutes == 4'd0);
  assign dark       = lead_blank || !blink_on_q;

  always_comb begin
    seg_d = 7'b0111111;
    case (digit)
      4'd0: seg_d = 7'b1000000;
      4'd1: seg_d = 7'b1111001;
      4'd2: seg_d = 7'b0100100;
      4'd3: seg_d = 7'b0110000;
      4'd4: seg_d = 7'b0011001;
      4'd5: seg_d = 7'b0010010;
      4'd6: seg_d = 7'b0000010;
      4'd7: seg_d = 7'b1111000;
      4'd8: seg_d = 7'b0000000;
      4'd9: seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase
    if (dark) seg_d = 7'b1111111;
    dp_d = !((idx_q == 2'd2) && !dark);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_anode
      assign anode_d[gi] = dark || (idx_q != 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q  <= '0;
      idx_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      anode_q     <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_q        <= 1'b1;
    end else begin
      prescale_q  <= prescale_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign anode    = anode_q;
  assign segments = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with SCAN_COUNT=4, BLINK_TICKS=2.
module tb_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] seconds = 4'd0, tens_seconds = 4'd0, minutes = 4'd0, tens_minutes = 4'd0;
  logic       done = 1'b0, blank_lead = 1'b0;
  logic [3:0] anode;
  logic [6:0] segments;
  logic       dp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_scan #(
    .SCAN_COUNT(4), .SCAN_WIDTH(2), .BLINK_TICKS(2), .BLINK_WIDTH(1)
  ) dut (
    .clk(clk), .reset(reset), .seconds(seconds), .tens_seconds(tens_seconds),
    .minutes(minutes), .tens_minutes(tens_minutes), .done(done),
    .blank_lead(blank_lead), .anode(anode), .segments(segments), .dp(dp)
  );

  typedef struct {
    logic [3:0] s, ts, m, tm;
    logic       bl;
    int         slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpv;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  task automatic check_out(input string name, input logic [3:0] an,
                           input logic [6:0] seg, input logic dpv);
    check({name, ".anode"}, {3'b0, anode}, {3'b0, an});
    check({name, ".segments"}, segments, seg);
    check({name, ".dp"}, {6'b0, dp}, {6'b0, dpv});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Two reset edges, then release; afterwards m negedges means m active edges seen.
  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 0, 4'b1110, 7'b0011001, 1'b1};
    vecs[1]  = '{4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 1, 4'b1101, 7'b0110000, 1'b1};
    vecs[2]  = '{4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 2, 4'b1011, 7'b0100100, 1'b0};
    vecs[3]  = '{4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 3, 4'b0111, 7'b1111001, 1'b1};
    vecs[4]  = '{4'd4, 4'd3, 4'd2, 4'd0, 1'b1, 3, 4'b1111, 7'b1111111, 1'b1};
    vecs[5]  = '{4'd4, 4'd3, 4'd2, 4'd0, 1'b0, 3, 4'b0111, 7'b1000000, 1'b1};
    vecs[6]  = '{4'hC, 4'd3, 4'd2, 4'd1, 1'b0, 0, 4'b1110, 7'b0111111, 1'b1};
    vecs[7]  = '{4'd5, 4'd0, 4'd0, 4'd0, 1'b0, 0, 4'b1110, 7'b0010010, 1'b1};
    vecs[8]  = '{4'd0, 4'd6, 4'd0, 4'd0, 1'b0, 1, 4'b1101, 7'b0000010, 1'b1};
    vecs[9]  = '{4'd0, 4'd0, 4'd7, 4'd0, 1'b0, 2, 4'b1011, 7'b1111000, 1'b0};
    vecs[10] = '{4'd8, 4'd0, 4'd0, 4'd0, 1'b0, 0, 4'b1110, 7'b0000000, 1'b1};
    vecs[11] = '{4'd0, 4'd9, 4'd0, 4'd0, 1'b0, 1, 4'b1101, 7'b0010000, 1'b1};
    vecs[12] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 4'b1110, 7'b1000000, 1'b1};
    vecs[13] = '{4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 2, 4'b1011, 7'b1000000, 1'b0};
    vecs[14] = '{4'd1, 4'd1, 4'd1, 4'hF, 1'b1, 3, 4'b0111, 7'b0111111, 1'b1};

    // Reset state and first-slot timing
    @(negedge clk);
    seconds = 4'd4; tens_seconds = 4'd3; minutes = 4'd2; tens_minutes = 4'd1;
    do_reset();
    reset = 1'b1;
    check_out("reset", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b0;
    cycles(1);
    check_out("first_after_release", 4'b1110, 7'b0011001, 1'b1);
    cycles(3);
    check_out("idx0_last_cycle", 4'b1110, 7'b0011001, 1'b1);
    cycles(1);
    check_out("idx1_appears", 4'b1101, 7'b0110000, 1'b1);
    cycles(13);
    check_out("repeat_16_idx0", 4'b1110, 7'b0011001, 1'b1);
    cycles(8);
    check_out("repeat_16_idx2", 4'b1011, 7'b0100100, 1'b0);

    // Table-driven decode, anode, dp and blanking
    for (int i = 0; i < 15; i++) begin
      seconds = vecs[i].s; tens_seconds = vecs[i].ts;
      minutes = vecs[i].m; tens_minutes = vecs[i].tm;
      blank_lead = vecs[i].bl; done = 1'b0;
      do_reset();
      cycles(4 * vecs[i].slot + 2);
      check_out($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dpv);
    end

    // Blink: 2 slots on, 2 slots off
    seconds = 4'd4; tens_seconds = 4'd3; minutes = 4'd2; tens_minutes = 4'd1;
    blank_lead = 1'b0; done = 1'b1;
    do_reset();
    cycles(2);
    check_out("blink_on_idx0", 4'b1110, 7'b0011001, 1'b1);
    cycles(4);
    check_out("blink_on_idx1", 4'b1101, 7'b0110000, 1'b1);
    cycles(4);
    check_out("blink_off_idx2", 4'b1111, 7'b1111111, 1'b1);
    // Drop done in the off phase (after edge 10)
    done = 1'b0;
    cycles(2);
    check_out("done_drop_visible", 4'b1011, 7'b0100100, 1'b0);
    // Reassert: starts in the on phase
    done = 1'b1;
    cycles(2);
    check_out("reassert_on_idx3", 4'b0111, 7'b1111001, 1'b1);
    cycles(4);
    check_out("reassert_on_idx0", 4'b1110, 7'b0011001, 1'b1);
    cycles(4);
    check_out("reassert_off_idx1", 4'b1111, 7'b1111111, 1'b1);

    // Reset mid-scan (visible slot)
    done = 1'b0;
    do_reset();
    cycles(6);
    reset = 1'b1;
    cycles(1);
    check_out("reset_mid_scan", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b0;
    cycles(2);
    check_out("restart_idx0", 4'b1110, 7'b0011001, 1'b1);

    // Reset mid-blink during off phase at index 2
    done = 1'b1;
    do_reset();
    cycles(10);
    check_out("pre_reset_off", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b1;
    cycles(1);
    check_out("reset_mid_blink", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b0;
    cycles(2);
    check_out("post_blink_reset_idx0_on", 4'b1110, 7'b0011001, 1'b1);
    cycles(2);
    check_out("post_blink_reset_slot_full", 4'b1110, 7'b0011001, 1'b1);
    cycles(1);
    check_out("post_blink_reset_idx1_on", 4'b1101, 7'b0110000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
